matrix_stream_reader: RTL and testbench

MATRIX_STREAM_READER -- requirements
Module: matrix_stream_reader

---
 rtl/matrix_stream_reader_pkg.sv | 18 +
 rtl/matrix_skid_fifo.sv | 44 ++++
 rtl/matrix_stream_reader.sv | 135 +++++++++++++
 tb/tb_matrix_stream_reader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_reader_pkg.sv
// Shared constants and FSM state type for the matrix stream reader.
// Geometry of the 10x10 matrix, address width and memory read latency.
package matrix_stream_reader_pkg;

  localparam int MAT_ROWS     = 10;
  localparam int MAT_COLS     = 10;
  localparam int MAT_ADDR_W   = 4;
  localparam int MAT_ELEMS    = 100;
  localparam int READ_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/matrix_skid_fifo.sv
// Two-entry output FIFO holding read data until downstream accepts it.
// Ports: clk, rst, push/push_data, pop, head_data, valid (not empty), count.
module matrix_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem[rp];
  assign valid     = (cnt != 2'd0);
  assign count     = cnt;

endmodule

// File: rtl/matrix_stream_reader.sv
// Streams a 10x10 matrix from a registered-read memory to a valid/ready sink.
// Ports: clk, rst, start, busy, done, mem_* memory side, out_* stream side.
// Define MATRIX_COL_MAJOR_EN for column-major (transposed) scan order.
module matrix_stream_reader
  import matrix_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en_ReadMat,
  output logic                  mem_en_WriteMat,
  output logic [MAT_ADDR_W-1:0] mem_rowAddr,
  output logic [MAT_ADDR_W-1:0] mem_colAddr,
  input  logic [DATA_WIDTH-1:0] mem_readData,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

`ifdef MATRIX_COL_MAJOR_EN
  localparam logic [MAT_ADDR_W-1:0] IN_MAX  = MAT_ADDR_W'(MAT_ROWS - 1);
  localparam logic [MAT_ADDR_W-1:0] OUT_MAX = MAT_ADDR_W'(MAT_COLS - 1);
`else
  localparam logic [MAT_ADDR_W-1:0] IN_MAX  = MAT_ADDR_W'(MAT_COLS - 1);
  localparam logic [MAT_ADDR_W-1:0] OUT_MAX = MAT_ADDR_W'(MAT_ROWS - 1);
`endif

  state_t                 state;
  state_t                 state_nx;
  logic [MAT_ADDR_W-1:0]  inner;
  logic [MAT_ADDR_W-1:0]  outer;
  logic                   rd_d1;
  logic                   last_d1;
  logic                   issue;
  logic                   load;
  logic                   pop;
  logic                   at_last;
  logic                   credit_ok;
  logic [1:0]             fcount;
  logic [DATA_WIDTH:0]    head;

  assign pop     = out_valid & out_ready;
  assign at_last = (inner == IN_MAX) && (outer == OUT_MAX);

  // Buffered + in-flight must leave room; a pop this cycle frees a slot.
  assign credit_ok = ({1'b0, fcount} + {2'b00, rd_d1}) <
                     (3'd2 + {2'b00, pop});

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = READ;
          load     = 1'b1;
        end
      end
      READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (at_last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as the FIFO empties so done follows the last transfer.
        if (!rd_d1 && (fcount == 2'd0 ||
            (fcount == 2'd1 && pop)))
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      inner   <= '0;
      outer   <= '0;
      rd_d1   <= 1'b0;
      last_d1 <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_d1   <= issue;
      last_d1 <= issue & at_last;
      if (load) begin
        inner <= '0;
        outer <= '0;
      end else if (issue && !at_last) begin
        if (inner == IN_MAX) begin
          inner <= '0;
          outer <= outer + 1'b1;
        end else begin
          inner <= inner + 1'b1;
        end
      end
    end
  end

  matrix_skid_fifo #(
    .W(DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_d1),
    .push_data ({last_d1, mem_readData}),
    .pop       (pop),
    .head_data (head),
    .valid     (out_valid),
    .count     (fcount)
  );

`ifdef MATRIX_COL_MAJOR_EN
  assign mem_rowAddr = inner;
  assign mem_colAddr = outer;
`else
  assign mem_rowAddr = outer;
  assign mem_colAddr = inner;
`endif

  assign out_data        = head[DATA_WIDTH-1:0];
  assign out_last        = head[DATA_WIDTH] & out_valid;
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign mem_en_ReadMat  = issue;
  assign mem_en_WriteMat = 1'b0;

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Self-checking bench for matrix_stream_reader against a queue scoreboard.
// Honours MATRIX_COL_MAJOR_EN for the expected element order.
module tb_matrix_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       mem_en_ReadMat;
  logic       mem_en_WriteMat;
  logic [3:0] mem_rowAddr;
  logic [3:0] mem_colAddr;
  logic [7:0] mem_readData = 8'd0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  int checks   = 0;
  int failures = 0;
  int exp_q [100];
  logic [7:0] mem [10][10];

  always #5 clk = ~clk;

  matrix_stream_reader #(.DATA_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .mem_en_ReadMat  (mem_en_ReadMat),
    .mem_en_WriteMat (mem_en_WriteMat),
    .mem_rowAddr     (mem_rowAddr),
    .mem_colAddr     (mem_colAddr),
    .mem_readData    (mem_readData),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last)
  );

  always @(posedge clk)
    if (mem_en_ReadMat && mem_rowAddr < 10 && mem_colAddr < 10)
      mem_readData <= mem[mem_rowAddr][mem_colAddr];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic run(input int mode, input int rst_at,
                     input int restart_at);
    int xfer = 0;
    int issued = 0;
    int dones = 0;
    int first_x = -1;
    int last_x = -1;
    int done_c = -1;
    int cyc = 0;
    bit stall = 0;
    bit fin = 0;
    logic [7:0] hold = 8'd0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    while (!fin && cyc < 400) begin
      @(negedge clk);
      start = (cyc == restart_at);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 0);
        2: out_ready = (cyc >= 20);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (mem_en_ReadMat) issued++;
      chk("addr_range", (mem_rowAddr <= 9 && mem_colAddr <= 9), 1);
      chk("we_zero", mem_en_WriteMat, 0);
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold);
      end
      stall = out_valid && !out_ready;
      hold = out_data;
      if (out_valid && out_ready) begin
        chk("data", out_data, exp_q[xfer]);
        chk("last", out_last, (xfer == 99));
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        xfer++;
      end
      chk("outstanding", (issued - xfer <= 2), 1);
      if (mode == 2 && cyc == 19) begin
        chk("held_issued", issued, 2);
        chk("held_valid", out_valid, 1);
        chk("held_data", out_data, exp_q[0]);
      end
      if (done) begin
        dones++;
        done_c = cyc;
      end
      if (rst_at >= 0 && xfer == rst_at + 1) begin
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd", mem_en_ReadMat, 0);
        chk("abort_data", out_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          #1;
          chk("abort_quiet", {out_valid, done, busy}, 0);
        end
        fin = 1;
      end else if (done_c >= 0 && cyc == done_c + 1) begin
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        fin = 1;
      end
      cyc++;
    end
    chk("timeout", fin, 1);
    if (rst_at < 0) begin
      chk("xfers", xfer, 100);
      chk("done_count", dones, 1);
      if (mode == 0) begin
        chk("first_xfer_cyc", first_x, 2);
        chk("last_xfer_cyc", last_x, 101);
        chk("done_cyc", done_c, 102);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        mem[r][c] = 8'(r * 10 + c);
    for (int k = 0; k < 100; k++) begin
`ifdef MATRIX_COL_MAJOR_EN
      exp_q[k] = (k % 10) * 10 + (k / 10);
`else
      exp_q[k] = k;
`endif
    end
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", mem_en_ReadMat, 0);
    chk("rst_we", mem_en_WriteMat, 0);
    chk("rst_addr", {mem_rowAddr, mem_colAddr}, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    run(0, -1, -1);
    run(1, -1, -1);
    run(2, -1, -1);
    run(0, 37, -1);
    run(3, -1, -1);
    run(0, -1, 52);
    run(3, -1, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
